// File: rtl/data_mem_ctrl.sv
// Load/store responder: drives one req/ack word-bus transaction per legal command, stalling the pipe meanwhile.
// Latency 3 cycles minimum (issue, REQ, DONE); stall holds the CPU until DONE, illegal commands pulse access_err.
module data_mem_ctrl #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        size_code,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              access_err,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             op_load;
    logic [2:0]       op_size;
    logic [1:0]       op_lane;

    logic        size_ok;
    logic        align_ok;
    logic        legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] byte_shift;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] ld_data;

    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b1;
        case (size_code)
            3'b000, 3'b001, 3'b011: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !mem_write;
            default:                size_ok = 1'b0;
        endcase
        case (size_code[1:0])
            2'b01:   align_ok = !addr[0];
            2'b11:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = (mem_read ^ mem_write) && size_ok && align_ok;
    end

    // Combinational so the PC freezes in the same cycle the command is presented.
    assign stall      = !reset && (((state == IDLE) && legal) || (state == REQ));
    assign access_err = !reset && (state == IDLE) && (mem_read || mem_write) && !legal;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata;
        case (size_code[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        byte_shift = bus_rdata >> {op_lane, 3'b000};
        byte_val   = byte_shift[7:0];
        half_val   = op_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_size)
            3'b000:  ld_data = {{24{byte_val[7]}}, byte_val};
            3'b001:  ld_data = {{16{half_val[15]}}, half_val};
            3'b100:  ld_data = {24'd0, byte_val};
            3'b101:  ld_data = {16'd0, half_val};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            op_load   <= 1'b0;
            op_size   <= 3'b000;
            op_lane   <= 2'b00;
            rdata     <= 32'd0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'd0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        state     <= REQ;
                        tmo_cnt   <= '0;
                        op_load   <= mem_read;
                        op_size   <= size_code;
                        op_lane   <= addr[1:0];
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= addr[ADDR_W+1:2];
                        bus_be    <= mem_write ? st_be : 4'b0000;
                        bus_wdata <= mem_write ? st_wdata : 32'd0;
                    end
                end
                REQ: begin
                    if (bus_ack || (tmo_cnt == CNT_W'(TIMEOUT - 1))) begin
                        state     <= DONE;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_be    <= 4'b0000;
                        bus_wdata <= 32'd0;
                        if (bus_ack) begin
                            if (op_load) rdata <= ld_data;
                        end else begin
                            // Timed-out load returns zero so software never sees stale data.
                            bus_err <= 1'b1;
                            if (op_load) rdata <= 32'd0;
                        end
                    end
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: drives on the falling edge, samples 1ns later.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  size_code = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        access_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    data_mem_ctrl #(.ADDR_W(30), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .size_code(size_code), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .access_err(access_err), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; size_code = 3'b000;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rdata, stall, access_err, bus_err} !== 35'd0) begin
            failures++; $display("FAIL reset_outputs got rdata=%h stall=%b aerr=%b berr=%b required all 0", rdata, stall, access_err, bus_err);
        end
        checks++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== 68'd0) begin
            failures++; $display("FAIL reset_bus got req=%b we=%b be=%b addr=%h wd=%h required all 0", bus_req, bus_we, bus_be, bus_addr, bus_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_byte(input logic [2:0] code, input logic [31:0] exp);
        @(negedge clk);
        mem_read = 1'b1; size_code = code; addr = 32'h0000_0103;
        bus_rdata = 32'h80FF_FF00; bus_ack = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL lb_issue_stall got %b required 1", stall); end
        @(negedge clk); #1;
        checks++;
        if ({bus_req, bus_we, bus_be, stall} !== 7'b1_0_0000_1) begin
            failures++; $display("FAIL lb_req got req=%b we=%b be=%b stall=%b required 1 0 0000 1", bus_req, bus_we, bus_be, stall);
        end
        checks++;
        if (bus_addr !== 30'h40) begin failures++; $display("FAIL lb_bus_addr got %h required 40", bus_addr); end
        @(negedge clk); #1;
        checks++;
        if (rdata !== exp) begin failures++; $display("FAIL lb_rdata code=%b got %h required %h", code, rdata, exp); end
        checks++;
        if ({stall, bus_req} !== 2'b00) begin failures++; $display("FAIL lb_done got stall=%b req=%b required 0 0", stall, bus_req); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_store_half();
        @(negedge clk);
        mem_write = 1'b1; size_code = 3'b001; addr = 32'h0000_0202;
        wdata = 32'h1234_ABCD; bus_ack = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({bus_req, bus_we, bus_be} !== 6'b1_1_1100) begin
            failures++; $display("FAIL sh_ctrl got req=%b we=%b be=%b required 1 1 1100", bus_req, bus_we, bus_be);
        end
        checks++;
        if (bus_wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata got %h required abcdabcd", bus_wdata); end
        checks++;
        if (bus_addr !== 30'h80) begin failures++; $display("FAIL sh_bus_addr got %h required 80", bus_addr); end
        @(negedge clk); #1;
        checks++;
        if (rdata !== 32'h0000_0080) begin failures++; $display("FAIL sh_rdata_hold got %h required 00000080", rdata); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [1:0]  rw   [3] = '{2'b10, 2'b11, 2'b01};
        logic [2:0]  code [3] = '{3'b011, 3'b011, 3'b100};
        logic [31:0] a    [3] = '{32'h6, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {mem_read, mem_write} = rw[i]; size_code = code[i]; addr = a[i];
            #1;
            checks++;
            if ({access_err, stall} !== 2'b10) begin
                failures++; $display("FAIL illegal_%0d got aerr=%b stall=%b required 1 0", i, access_err, stall);
            end
            @(negedge clk);
            idle_inputs();
            #1;
            checks++;
            if ({access_err, bus_req, stall} !== 3'b000) begin
                failures++; $display("FAIL illegal_after_%0d got aerr=%b req=%b stall=%b required 0 0 0", i, access_err, bus_req, stall);
            end
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        @(negedge clk);
        mem_read = 1'b1; size_code = 3'b011; addr = 32'h0000_0010; bus_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus_req) break;
            req_cycles++;
            @(negedge clk);
        end
        checks++;
        if (req_cycles !== 16) begin failures++; $display("FAIL timeout_req_cycles got %0d required 16", req_cycles); end
        checks++;
        if ({bus_err, stall} !== 2'b10) begin failures++; $display("FAIL timeout_done got berr=%b stall=%b required 1 0", bus_err, stall); end
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL timeout_rdata got %h required 00000000", rdata); end
        idle_inputs();
        @(negedge clk); #1;
        checks++;
        if ({bus_err, bus_req, stall} !== 3'b000) begin
            failures++; $display("FAIL timeout_idle got berr=%b req=%b stall=%b required 0 0 0", bus_err, bus_req, stall);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mem_read = 1'b1; size_code = 3'b011; addr = 32'h0000_0020;
        bus_rdata = 32'h1122_3344; bus_ack = 1'b0;
        repeat (6) @(negedge clk);
        bus_ack = 1'b1;
        #1;
        checks++;
        if ({bus_req, stall} !== 2'b11) begin failures++; $display("FAIL b2b_wait got req=%b stall=%b required 1 1", bus_req, stall); end
        @(negedge clk); #1;
        checks++;
        if (rdata !== 32'h1122_3344) begin failures++; $display("FAIL b2b_load_rdata got %h required 11223344", rdata); end
        idle_inputs();
        @(negedge clk);
        mem_write = 1'b1; size_code = 3'b011; addr = 32'h0000_0024; wdata = 32'hCAFE_BABE;
        #1;
        checks++;
        if ({bus_req, stall} !== 2'b01) begin failures++; $display("FAIL b2b_idle got req=%b stall=%b required 0 1", bus_req, stall); end
        @(negedge clk); #1;
        checks++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b1111, 30'h9, 32'hCAFE_BABE}) begin
            failures++; $display("FAIL b2b_sw_bus got req=%b we=%b be=%b addr=%h wd=%h required 1 1 1111 9 cafebabe", bus_req, bus_we, bus_be, bus_addr, bus_wdata);
        end
        bus_ack = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (rdata !== 32'h1122_3344) begin failures++; $display("FAIL b2b_rdata_hold got %h required 11223344", rdata); end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        mem_read = 1'b1; size_code = 3'b011; addr = 32'h0000_0030; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_req, stall, bus_err} !== 3'b000) begin
            failures++; $display("FAIL rst_mid_ctrl got req=%b stall=%b berr=%b required 0 0 0", bus_req, stall, bus_err);
        end
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL rst_mid_rdata got %h required 00000000", rdata); end
        bus_rdata = 32'hFFFF_FFFF; bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus_req, rdata} !== 33'd0) begin failures++; $display("FAIL rst_late_ack got req=%b rdata=%h required 0 0", bus_req, rdata); end
        bus_ack = 1'b0;
        mem_read = 1'b1; size_code = 3'b011; addr = 32'h2;
        #1;
        checks++;
        if (access_err !== 1'b1) begin failures++; $display("FAIL rst_state_idle got aerr=%b required 1", access_err); end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_byte(3'b000, 32'hFFFF_FF80);
        test_load_byte(3'b100, 32'h0000_0080);
        test_store_half();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Responder on the datapath side of the memRead/memWrite commands issued by the instruction decoder.
- Accepts a load or store command, with access size and signedness taken from opCode[2:0].
- Runs a req/ack transaction on a word-wide data-memory bus and stalls the pipeline until that transaction completes.
- Returns lane-aligned, sign- or zero-extended load data, and flags illegal accesses and bus timeouts.

Parameters:
ADDR_W, 30, word-address width on the memory bus (byte address bits [ADDR_W+1:2]).
TIMEOUT, 16, maximum cycles in REQ without bus_ack before the transaction is aborted (must be at least 1).

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
mem_read  in  1  load command from the control unit
mem_write  in  1  store command from the control unit
size_code  in  3  opCode[2:0]: 000 byte, 001 half, 011 word, 100 byte unsigned, 101 half unsigned (unsigned codes are loads only)
addr  in  32  byte address from the ALU
wdata  in  32  store data (rt)
rdata  out  32  extended load result
stall  out  1  freezes PC and pipeline registers while high
access_err  out  1  one-cycle pulse for an illegal access
bus_err  out  1  one-cycle pulse when a transaction times out
bus_req  out  1  memory request
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word address
bus_be  out  4  byte enables, bit i = byte lane i
bus_wdata  out  32  lane-replicated write data
bus_rdata  in  32  memory read word
bus_ack  in  1  memory completion, valid only while bus_req is high

Behaviour:
- States: IDLE, REQ, DONE.
- Reset values:
  - state IDLE; rdata 0; bus_req, bus_we, bus_be, bus_addr, bus_wdata all 0.
  - access_err 0; bus_err 0; stall 0.
  - Timeout counter 0.
- A command is "legal" when all of the following hold:
  - exactly one of mem_read or mem_write is high;
  - size_code is in {000, 001, 011, 100, 101};
  - size_code is not 100 or 101 when mem_write is high;
  - the address is aligned: half requires addr[0]=0, word requires addr[1:0]=00.
- IDLE:
  - Legal command: latch the operation, size, addr[1:0] and data. On the next edge go to REQ with bus_req=1 and the bus outputs driven.
  - Any other command with mem_read or mem_write high: access_err=1 for that cycle, no bus activity, stay in IDLE.
- stall is combinational: (IDLE and legal command) or REQ. stall is 0 in DONE and 0 on an illegal command.
- REQ:
  - bus_req and all bus outputs are held stable until bus_ack.
  - On bus_ack: capture read data, drop bus_req on the next edge, go to DONE.
  - Counter increments each REQ cycle without bus_ack. When it reaches TIMEOUT: drop bus_req, go to DONE, bus_err=1 during DONE, and load rdata with 0.
- DONE:
  - Exactly one cycle; rdata is valid; the CPU advances.
  - Inputs are ignored in this cycle, because the completing instruction is still presented.
  - Always return to IDLE. Minimum load/store latency is 3 cycles: issue, REQ with immediate ack, DONE.
- Store lanes, with bus_addr = addr[ADDR_W+1:2]:
  - SB: bus_wdata = {4{wdata[7:0]}}, bus_be = 0001 << addr[1:0].
  - SH: bus_wdata = {2{wdata[15:0]}}, bus_be = 0011 << (addr[1]*2).
  - SW: bus_wdata = wdata, bus_be = 1111.
- Load lanes, little-endian:
  - Select the byte at bus_rdata[8*addr[1:0] +: 8], or the half at bus_rdata[16*addr[1] +: 16].
  - Codes 000/001 sign-extend; 100/101 zero-extend; 011 returns the full word.
  - For loads bus_be = 0000 with bus_we = 0.
- rdata updates only at load completion and holds otherwise. Stores and errors leave it unchanged, except that a load timeout sets it to 0.
- bus_ack while not in REQ is ignored.
- Reset asserted in any state: IDLE on that edge, bus_req low from the next cycle, and any in-flight result is discarded.
- Timeout counter clears on entry to REQ.

Test Plan:
- LB from addr 0x00000103 with bus_rdata 0x80FFFF00 and ack on the first REQ cycle -> bus_addr 0x40, stall high 2 cycles, rdata 0xFFFFFF80 in DONE; with code 100, rdata is 0x00000080.
- SH of wdata 0x1234ABCD to addr 0x00000202 -> bus_we 1, bus_be 1100, bus_wdata 0xABCDABCD, bus_addr 0x80.
- LW to addr 0x00000006 -> access_err pulses 1 cycle, bus_req stays 0, stall 0; repeat with mem_read and mem_write both high, and with a store using code 100 -> same result.
- LW with ack withheld, TIMEOUT=16 -> bus_req high exactly 16 cycles, then DONE with bus_err=1 and rdata 0x00000000, then IDLE.
- LW with ack delayed 5 cycles, then a back-to-back SW presented the cycle after DONE -> second bus_req rises 1 cycle after IDLE is re-entered, and the first rdata holds through the store.
- Reset pulsed mid-REQ -> bus_req 0 the next cycle, stall 0, rdata 0, state IDLE; a late bus_ack has no effect.
